// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrain
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, PC stall/load control and the
// IF/ID holding register with a valid/ready handshake towards decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_stall,
  output logic            pc_load,
  output logic [XLEN-1:0] new_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  output logic            flush
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    imem_req   = 1'b0;
    imem_addr  = pc_in;
    pc_stall   = 1'b1;
    pc_load    = 1'b0;
    new_pc     = '0;
    flush      = 1'b0;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        imem_req = ~redirect;
        if (!redirect && imem_gnt) begin
          req_pc_d = pc_in;
          pc_stall = 1'b0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid && !redirect) begin
          if_instr_d = imem_rdata;
          if_pc_d    = req_pc_q;
          if_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      StDrain: begin
        if (imem_rvalid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    // A redirect overrides everything; a fetch still in flight must be drained first.
    if (redirect) begin
      pc_load    = 1'b1;
      pc_stall   = 1'b0;
      new_pc     = {redirect_pc[XLEN-1:2], 2'b00};
      flush      = 1'b1;
      if_valid_d = 1'b0;
      if ((state_q == StWait || state_q == StDrain) && !imem_rvalid) begin
        state_d = StDrain;
      end else begin
        state_d = StReq;
      end
    end

    if (rst) begin
      imem_req = 1'b0;
      pc_stall = 1'b1;
      pc_load  = 1'b0;
      new_pc   = '0;
      flush    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule
